// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues in-order SRAM reads, tracks in-flight responses,
// discards stale data after redirects and buffers fetched words for the ID stage.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h1C000000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IQ_DEPTH        = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic        fetch_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int QW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(IQ_DEPTH + 1);

  function automatic logic [PW-1:0] pend_next(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUTSTANDING - 1)) pend_next = '0;
    else pend_next = p + PW'(1);
  endfunction

  function automatic logic [QW-1:0] iq_next(input logic [QW-1:0] p);
    if (p == QW'(IQ_DEPTH - 1)) iq_next = '0;
    else iq_next = p + QW'(1);
  endfunction

  logic          run_r;
  logic [31:0]   req_pc_r;
  logic          adef_hold_r;
  logic [OW-1:0] out_cnt_r;
  logic [OW-1:0] discard_cnt_r;
  logic [31:0]   pend_pc_r [MAX_OUTSTANDING];
  logic [PW-1:0] pend_wr_r, pend_rd_r;
  logic [64:0]   iq_mem_r [IQ_DEPTH];
  logic [QW-1:0] iq_wr_r, iq_rd_r;
  logic [CW-1:0] iq_cnt_r;

  logic        data_ok_s, drop_s, resp_push_s, adef_push_s, iq_push_s, iq_pop_s;
  logic        aligned_s, room_s, req_s, hs_s;
  logic [31:0] live_s;
  logic [64:0] iq_entry_s;

  // Ignore data_ok with nothing in flight; live_s counts responses that will be kept.
  assign data_ok_s   = inst_sram_data_ok & (out_cnt_r != '0);
  assign live_s      = 32'(out_cnt_r) - 32'(discard_cnt_r);
  assign room_s      = (32'(iq_cnt_r) + live_s) < 32'(IQ_DEPTH);
  assign aligned_s   = (req_pc_r[1:0] == 2'b00);
  assign req_s       = run_r & ~redirect_valid & ~fetch_stall & ~adef_hold_r & aligned_s
                     & (32'(out_cnt_r) < 32'(MAX_OUTSTANDING)) & room_s;
  assign hs_s        = req_s & inst_sram_addr_ok;
  assign drop_s      = data_ok_s & (discard_cnt_r != '0);
  assign resp_push_s = data_ok_s & ~drop_s & ~redirect_valid;
  assign adef_push_s = run_r & ~redirect_valid & ~adef_hold_r & ~aligned_s
                     & (live_s == 32'd0) & room_s;
  assign iq_push_s   = resp_push_s | adef_push_s;
  assign iq_pop_s    = fs_to_ds_valid & ds_allowin;

  // Select the entry written into the instruction queue this cycle.
  always_comb begin
    iq_entry_s = 65'd0;
    if (adef_push_s) iq_entry_s = {1'b1, 32'h0000_0000, req_pc_r};
    else             iq_entry_s = {1'b0, inst_sram_rdata, pend_pc_r[pend_rd_r]};
  end

  // Fetch PC, in-flight counters and the address-error latch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_r         <= 1'b0;
      req_pc_r      <= RESET_PC;
      adef_hold_r   <= 1'b0;
      out_cnt_r     <= '0;
      discard_cnt_r <= '0;
    end else begin
      run_r     <= 1'b1;
      out_cnt_r <= out_cnt_r + OW'(hs_s) - OW'(data_ok_s);
      if (redirect_valid) begin
        req_pc_r      <= redirect_pc;
        adef_hold_r   <= 1'b0;
        // Already-discarded responses are part of out_cnt, so every survivor is now stale.
        discard_cnt_r <= out_cnt_r - OW'(data_ok_s);
      end else begin
        if (hs_s)        req_pc_r      <= req_pc_r + 32'd4;
        if (adef_push_s) adef_hold_r   <= 1'b1;
        if (drop_s)      discard_cnt_r <= discard_cnt_r - OW'(1);
      end
    end
  end

  // PCs of accepted requests, consumed in order by data_ok.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_wr_r <= '0;
      pend_rd_r <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) pend_pc_r[i] <= 32'd0;
    end else begin
      if (hs_s) begin
        pend_pc_r[pend_wr_r] <= req_pc_r;
        pend_wr_r            <= pend_next(pend_wr_r);
      end
      if (data_ok_s) pend_rd_r <= pend_next(pend_rd_r);
    end
  end

  // Instruction queue; a redirect flushes it in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iq_wr_r  <= '0;
      iq_rd_r  <= '0;
      iq_cnt_r <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) iq_mem_r[i] <= 65'd0;
    end else if (redirect_valid) begin
      iq_wr_r  <= '0;
      iq_rd_r  <= '0;
      iq_cnt_r <= '0;
    end else begin
      if (iq_push_s) begin
        iq_mem_r[iq_wr_r] <= iq_entry_s;
        iq_wr_r           <= iq_next(iq_wr_r);
      end
      if (iq_pop_s) iq_rd_r <= iq_next(iq_rd_r);
      iq_cnt_r <= iq_cnt_r + CW'(iq_push_s) - CW'(iq_pop_s);
    end
  end

  assign fs_to_ds_valid  = (iq_cnt_r != '0) & ~redirect_valid;
  assign fs_to_ds_bus    = (iq_cnt_r != '0) ? iq_mem_r[iq_rd_r] : 65'd0;
  assign inst_sram_req   = req_s;
  assign inst_sram_addr  = req_pc_r;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0000_0000;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order SRAM responder plus a sequential-PC stream model.
module tb_if_fetch_unit;
  localparam logic [31:0] RPC = 32'h1C000000;
  localparam int MAXO = 2;

  logic        clk = 1'b0, resetn = 1'b1;
  logic        ds_allowin = 1'b0, fetch_stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        fs_to_ds_valid, inst_sram_req, inst_sram_wr;
  logic [64:0] fs_to_ds_bus;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata, inst_sram_addr;
  logic [31:0] inst_sram_rdata = 32'd0;
  logic        inst_sram_addr_ok = 1'b0, inst_sram_data_ok = 1'b0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RPC), .MAX_OUTSTANDING(MAXO), .IQ_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .ds_allowin(ds_allowin), .fetch_stall(fetch_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok));

  typedef struct { logic [31:0] addr; int ready; } rsp_t;
  typedef struct { logic allowin; logic exp_req; logic [31:0] exp_addr;
                   logic exp_valid; logic [31:0] exp_pc; } vec_t;

  int checks = 0, failures = 0, cyc = 0;
  int pops = 0, hs_cnt = 0, ao_wait = 0, max_extra = 0;
  bit rand_mode = 1'b0, m_dead = 1'b0;
  logic [31:0] m_next = RPC;
  rsp_t rq[$];
  logic s_req, s_valid;
  logic [31:0] s_addr;
  logic [64:0] s_bus;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5AA5A5;
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive responder, sample at mid-cycle, update the model, advance.
  task automatic tick();
    rsp_t h;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = $urandom;
    if (rq.size() > 0 && rq[0].ready <= cyc) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = mem_word(rq[0].addr);
    end
    inst_sram_addr_ok = (ao_wait == 0);
    #1;
    s_req = inst_sram_req; s_addr = inst_sram_addr; s_valid = fs_to_ds_valid; s_bus = fs_to_ds_bus;
    if (s_req) chk("req_addr_aligned", 65'(s_addr[1:0]), 65'd0);
    if (m_dead) chk("req_after_adef", 65'(s_req), 65'd0);
    if (redirect_valid) chk("valid_during_redirect", 65'(s_valid), 65'd0);
    if (s_valid && ds_allowin) begin
      pops++;
      if (m_dead) chk("output_after_adef", 65'(s_valid), 65'd0);
      else if (m_next[1:0] != 2'b00) begin
        chk("adef_entry", s_bus, {1'b1, 32'h0, m_next});
        m_dead = 1'b1;
      end else begin
        chk("out_entry", s_bus, {1'b0, mem_word(m_next), m_next});
        m_next = m_next + 32'd4;
      end
    end
    if (redirect_valid) begin m_next = redirect_pc; m_dead = 1'b0; end
    if (inst_sram_data_ok) void'(rq.pop_front());
    if (s_req && inst_sram_addr_ok) begin
      h.addr  = s_addr;
      h.ready = cyc + 1 + (rand_mode ? $urandom_range(0, max_extra) : max_extra);
      rq.push_back(h);
      hs_cnt++;
      chk("outstanding_over_max", 65'(rq.size() > MAXO), 65'd0);
      ao_wait = rand_mode ? $urandom_range(0, 3) : 0;
    end else if (s_req && ao_wait > 0) ao_wait--;
    @(posedge clk); cyc++; @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0; redirect_valid = 1'b0; fetch_stall = 1'b0; ds_allowin = 1'b0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
    #1;
    chk("reset_req", 65'(inst_sram_req), 65'd0);
    chk("reset_valid", 65'(fs_to_ds_valid), 65'd0);
    chk("reset_bus", fs_to_ds_bus, 65'd0);
    rq.delete(); ao_wait = 0; m_next = RPC; m_dead = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    vec_t vecs[6];
    int p0, h0;
    bit got;
    vecs[0] = '{1'b1, 1'b0, 32'h0,      1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, RPC,        1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, RPC + 32'd4,  1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b1, RPC + 32'd8,  1'b1, RPC};
    vecs[4] = '{1'b1, 1'b1, RPC + 32'd12, 1'b1, RPC + 32'd4};
    vecs[5] = '{1'b1, 1'b1, RPC + 32'd16, 1'b1, RPC + 32'd8};

    // Streaming from reset, checked cycle by cycle.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ds_allowin = vecs[i].allowin;
      tick();
      chk($sformatf("vec%0d_req", i), 65'(s_req), 65'(vecs[i].exp_req));
      if (vecs[i].exp_req) chk($sformatf("vec%0d_addr", i), 65'(s_addr), 65'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_valid", i), 65'(s_valid), 65'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_pc", i), 65'(s_bus[31:0]), 65'(vecs[i].exp_pc));
    end

    // Backpressure: queue fills to four entries, then drains in order.
    do_reset();
    h0 = hs_cnt;
    repeat (12) tick();
    chk("bp_handshakes", 65'(hs_cnt - h0), 65'd4);
    chk("bp_req_low", 65'(s_req), 65'd0);
    chk("bp_valid", 65'(s_valid), 65'd1);
    ds_allowin = 1'b1; p0 = pops;
    repeat (12) tick();
    chk("bp_drain_progress", 65'(pops - p0 >= 8), 65'd1);

    // Redirect with two requests in flight.
    max_extra = 3; got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin tick(); got = (rq.size() == 2); end
    chk("two_outstanding_reached", 65'(got), 65'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h1C000100;
    tick();
    redirect_valid = 1'b0; max_extra = 0; p0 = pops; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin tick(); got = (pops > p0); end
    chk("redirect_output_seen", 65'(got), 65'd1);
    chk("redirect_first_pc", 65'(s_bus[31:0]), 65'h1C000100);

    // Misaligned redirect: one address-error entry, then silence.
    redirect_valid = 1'b1; redirect_pc = 32'h1C000102;
    tick();
    redirect_valid = 1'b0; p0 = pops; h0 = hs_cnt;
    repeat (10) tick();
    chk("adef_single_output", 65'(pops - p0), 65'd1);
    chk("adef_no_handshake", 65'(hs_cnt - h0), 65'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h1C000200;
    tick();
    redirect_valid = 1'b0; p0 = pops;
    repeat (10) tick();
    chk("restart_after_adef", 65'(pops - p0 > 0), 65'd1);

    // Randomized traffic against the stream model.
    rand_mode = 1'b1; max_extra = 2; p0 = pops;
    for (int i = 0; i < 3000; i++) begin
      ds_allowin     = ($urandom_range(0, 9) < 7);
      fetch_stall    = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 49) == 0);
      redirect_pc    = {12'h1C0, 8'($urandom), 10'($urandom), ($urandom_range(0, 19) == 0) ? 2'b10 : 2'b00};
      tick();
    end
    redirect_valid = 1'b0; fetch_stall = 1'b0;
    chk("random_progress", 65'(pops - p0 > 200), 65'd1);

    // Reset pulse in the middle of a stream.
    rand_mode = 1'b0; max_extra = 0; ds_allowin = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h1C000400;
    tick();
    redirect_valid = 1'b0;
    repeat (6) tick();
    chk("pre_reset_valid", 65'(s_valid), 65'd1);
    do_reset();
    ds_allowin = 1'b1;
    tick();
    chk("post_reset_c0_req", 65'(s_req), 65'd0);
    tick();
    chk("post_reset_c1_req", 65'(s_req), 65'd1);
    chk("post_reset_c1_addr", 65'(s_addr), 65'(RPC));
    p0 = pops;
    repeat (8) tick();
    chk("post_reset_progress", 65'(pops - p0 >= 4), 65'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
